// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one UART transmitter between a 1-byte register
// read path and a 2-byte ALU result path; bytes go out LSB first under Busy handshake.
module uart_tx_scheduler #(
  parameter int DATA_WIDTH   = 8,
  parameter int BUSY_TIMEOUT = 255
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [DATA_WIDTH-1:0]   RD_DATA,
  input  logic                    RD_REQ,
  output logic                    RD_ACK,
  input  logic [2*DATA_WIDTH-1:0] ALU_OUT,
  input  logic                    ALU_REQ,
  output logic                    ALU_ACK,
  input  logic                    Busy,
  output logic [DATA_WIDTH-1:0]   TX_P_DATA,
  output logic                    TX_DATA_VALID,
  output logic                    CTRL_BUSY,
  output logic                    TIMEOUT_ERR
);

  localparam int TO_W = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(BUSY_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GRANT,
    S_SEND,
    S_WAIT_HI,
    S_WAIT_LO
  } state_t;

  state_t                  r_state;
  state_t                  w_next_state;
  logic [2*DATA_WIDTH-1:0] r_shift;
  logic [1:0]              r_byte_cnt;
  logic [TO_W-1:0]         r_to_cnt;
  logic                    r_ptr_alu;
  logic                    r_rd_ack;
  logic                    r_alu_ack;
  logic [DATA_WIDTH-1:0]   r_tx_data;
  logic                    r_tx_valid;
  logic                    r_ctrl_busy;
  logic                    r_timeout_err;

  logic w_grant_rd;
  logic w_grant_alu;
  logic w_contend;
  logic w_send;
  logic w_to_inc;
  logic w_to_fire;
  logic w_shift;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // NOTE: every combinational output gets a default first so no path leaves
  // a signal unassigned and infers a latch.
  always_comb begin
    w_next_state = r_state;
    w_grant_rd   = 1'b0;
    w_grant_alu  = 1'b0;
    w_contend    = 1'b0;
    w_send       = 1'b0;
    w_to_inc     = 1'b0;
    w_to_fire    = 1'b0;
    w_shift      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!Busy && (RD_REQ || ALU_REQ)) w_next_state = S_GRANT;
      end
      S_GRANT: begin
        w_contend = RD_REQ && ALU_REQ;
        if (w_contend) begin
          w_grant_alu = r_ptr_alu;
          w_grant_rd  = !r_ptr_alu;
        end else begin
          w_grant_rd  = RD_REQ;
          w_grant_alu = ALU_REQ;
        end
        // A request withdrawn before grant leaves nothing to send.
        w_next_state = (w_grant_rd || w_grant_alu) ? S_SEND : S_IDLE;
      end
      S_SEND: begin
        w_send       = 1'b1;
        w_next_state = S_WAIT_HI;
      end
      S_WAIT_HI: begin
        if (Busy) begin
          w_next_state = S_WAIT_LO;
        end else begin
          w_to_inc = 1'b1;
          if (r_to_cnt == TO_LAST) begin
            w_to_fire    = 1'b1;
            w_next_state = S_IDLE;
          end
        end
      end
      S_WAIT_LO: begin
        if (!Busy) begin
          w_shift      = 1'b1;
          w_next_state = (r_byte_cnt == 2'd1) ? S_IDLE : S_SEND;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_shift       <= '0;
      r_byte_cnt    <= '0;
      r_to_cnt      <= '0;
      r_ptr_alu     <= 1'b0;
      r_rd_ack      <= 1'b0;
      r_alu_ack     <= 1'b0;
      r_tx_data     <= '0;
      r_tx_valid    <= 1'b0;
      r_ctrl_busy   <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_rd_ack    <= w_grant_rd;
      r_alu_ack   <= w_grant_alu;
      r_tx_valid  <= w_send;
      r_ctrl_busy <= (w_next_state != S_IDLE);

      if (w_grant_rd) begin
        r_shift    <= {{DATA_WIDTH{1'b0}}, RD_DATA};
        r_byte_cnt <= 2'd1;
      end else if (w_grant_alu) begin
        r_shift    <= ALU_OUT;
        r_byte_cnt <= 2'd2;
      end else if (w_shift) begin
        r_shift    <= r_shift >> DATA_WIDTH;
        r_byte_cnt <= r_byte_cnt - 2'd1;
      end else if (w_to_fire) begin
        r_byte_cnt <= '0;
      end

      if (w_contend) r_ptr_alu <= !r_ptr_alu;

      if (w_send) begin
        r_tx_data <= r_shift[DATA_WIDTH-1:0];
        r_to_cnt  <= '0;
      end else if (w_to_inc) begin
        r_to_cnt <= r_to_cnt + 1'b1;
      end

      if (w_to_fire) r_timeout_err <= 1'b1;
    end
  end

  assign RD_ACK        = r_rd_ack;
  assign ALU_ACK       = r_alu_ack;
  assign TX_P_DATA     = r_tx_data;
  assign TX_DATA_VALID = r_tx_valid;
  assign CTRL_BUSY     = r_ctrl_busy;
  assign TIMEOUT_ERR   = r_timeout_err;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Scoreboard bench for uart_tx_scheduler: stimulus queues expected grants and bytes,
// a monitor pops them as the DUT acknowledges and strobes TX_DATA_VALID.
module tb_uart_tx_scheduler;

  localparam int DW           = 8;
  localparam int BUSY_TIMEOUT = 255;
  localparam int BUSY_LEN     = 100;

  localparam int S_RD_ACK  = 0;
  localparam int S_ALU_ACK = 1;
  localparam int S_VALID   = 2;
  localparam int S_CBUSY   = 3;
  localparam int S_ERR     = 4;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic [DW-1:0] RD_DATA = '0;
  logic          RD_REQ = 1'b0;
  logic          RD_ACK;
  logic [2*DW-1:0] ALU_OUT = '0;
  logic          ALU_REQ = 1'b0;
  logic          ALU_ACK;
  logic          Busy;
  logic [DW-1:0] TX_P_DATA;
  logic          TX_DATA_VALID;
  logic          CTRL_BUSY;
  logic          TIMEOUT_ERR;

  logic busy_model = 1'b0;
  logic busy_force = 1'b0;
  logic busy_en    = 1'b1;
  assign Busy = busy_model | busy_force;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int busy_fall_cyc = 0;
  int rd_ack_cnt  = 0;
  int alu_ack_cnt = 0;

  logic [DW-1:0] exp_q[$];
  bit            ack_q[$];

  uart_tx_scheduler #(.DATA_WIDTH(DW), .BUSY_TIMEOUT(BUSY_TIMEOUT)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .RD_DATA      (RD_DATA),
    .RD_REQ       (RD_REQ),
    .RD_ACK       (RD_ACK),
    .ALU_OUT      (ALU_OUT),
    .ALU_REQ      (ALU_REQ),
    .ALU_ACK      (ALU_ACK),
    .Busy         (Busy),
    .TX_P_DATA    (TX_P_DATA),
    .TX_DATA_VALID(TX_DATA_VALID),
    .CTRL_BUSY    (CTRL_BUSY),
    .TIMEOUT_ERR  (TIMEOUT_ERR)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic sig(input int s);
    case (s)
      S_RD_ACK:  return RD_ACK;
      S_ALU_ACK: return ALU_ACK;
      S_VALID:   return TX_DATA_VALID;
      S_CBUSY:   return CTRL_BUSY;
      default:   return TIMEOUT_ERR;
    endcase
  endfunction

  task automatic wait_sig(input int s, input logic val, input int budget, input string name);
    int n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (sig(s) !== val && n < budget);
    check(name, sig(s), val);
  endtask

  // Transmitter model: Busy rises 2 cycles after each strobe and stays high BUSY_LEN cycles.
  initial begin
    forever begin
      @(negedge CLK);
      if (busy_en && TX_DATA_VALID) begin
        repeat (2) @(negedge CLK);
        busy_model = 1'b1;
        repeat (BUSY_LEN) @(negedge CLK);
        busy_model    = 1'b0;
        busy_fall_cyc = cyc;
      end
    end
  end

  initial begin : monitor
    logic [DW-1:0] exp_b;
    forever begin
      @(negedge CLK);
      if (RST) begin
        if (TX_DATA_VALID) begin
          if (exp_q.size() == 0) check("tx_unexpected", exp_q.size(), 1);
          else begin
            exp_b = exp_q.pop_front();
            check("tx_byte", TX_P_DATA, exp_b);
          end
        end
        if (RD_ACK) begin
          rd_ack_cnt++;
          if (ack_q.size() == 0) check("rd_ack_unexpected", ack_q.size(), 1);
          else check("grant_order_rd", ack_q.pop_front(), 0);
        end
        if (ALU_ACK) begin
          alu_ack_cnt++;
          if (ack_q.size() == 0) check("alu_ack_unexpected", ack_q.size(), 1);
          else check("grant_order_alu", ack_q.pop_front(), 1);
        end
      end
    end
  end

  initial begin : stimulus
    int t0;
    int base;
    int rd_left, alu_left, n;
    bit rd_raise, alu_raise;

    // Reset state
    repeat (3) @(negedge CLK);
    check("rst_tx_data", TX_P_DATA, 0);
    check("rst_tx_valid", TX_DATA_VALID, 0);
    check("rst_acks", {RD_ACK, ALU_ACK}, 0);
    check("rst_ctrl_busy", CTRL_BUSY, 0);
    check("rst_timeout_err", TIMEOUT_ERR, 0);
    RST = 1'b1;
    repeat (2) @(negedge CLK);

    // Single RD: latency, one byte, CTRL_BUSY drops the cycle after Busy falls
    base = rd_ack_cnt;
    ack_q.push_back(1'b0);
    exp_q.push_back(8'hA5);
    RD_DATA = 8'hA5;
    RD_REQ  = 1'b1;
    t0 = cyc;
    wait_sig(S_RD_ACK, 1'b1, 10, "rd_ack_seen");
    check("rd_ack_latency", cyc - t0, 2);
    RD_REQ = 1'b0;
    wait_sig(S_VALID, 1'b1, 10, "rd_valid_seen");
    check("rd_valid_latency", cyc - t0, 3);
    wait_sig(S_CBUSY, 1'b0, 300, "rd_frame_done");
    check("rd_ctrl_busy_drop", cyc - busy_fall_cyc, 1);
    check("rd_ack_once", rd_ack_cnt - base, 1);
    check("rd_queue_empty", exp_q.size(), 0);

    // Single ALU: LSB then MSB, second strobe 2 cycles after Busy falls
    ack_q.push_back(1'b1);
    exp_q.push_back(8'h34);
    exp_q.push_back(8'h12);
    ALU_OUT = 16'h1234;
    ALU_REQ = 1'b1;
    wait_sig(S_ALU_ACK, 1'b1, 10, "alu_ack_seen");
    ALU_REQ = 1'b0;
    wait_sig(S_VALID, 1'b1, 10, "alu_valid1_seen");
    wait_sig(S_VALID, 1'b0, 3, "alu_valid1_pulse");
    wait_sig(S_VALID, 1'b1, 300, "alu_valid2_seen");
    check("alu_byte2_latency", cyc - busy_fall_cyc, 2);
    wait_sig(S_CBUSY, 1'b0, 300, "alu_frame_done");
    check("alu_queue_empty", exp_q.size(), 0);

    // Contention: RD, ALU, RD, ALU with re-requests after each ACK
    ack_q.push_back(1'b0); exp_q.push_back(8'h11);
    ack_q.push_back(1'b1); exp_q.push_back(8'hB2); exp_q.push_back(8'hA1);
    ack_q.push_back(1'b0); exp_q.push_back(8'h22);
    ack_q.push_back(1'b1); exp_q.push_back(8'hD4); exp_q.push_back(8'hC3);
    base = rd_ack_cnt + alu_ack_cnt;
    RD_DATA = 8'h11;
    ALU_OUT = 16'hA1B2;
    RD_REQ  = 1'b1;
    ALU_REQ = 1'b1;
    rd_left = 2; alu_left = 2; rd_raise = 0; alu_raise = 0; n = 0;
    while ((rd_left > 0 || alu_left > 0) && n < 3000) begin
      @(negedge CLK);
      n++;
      if (rd_raise)  begin RD_DATA = 8'h22;    RD_REQ = 1'b1;  rd_raise = 0;  end
      if (alu_raise) begin ALU_OUT = 16'hC3D4; ALU_REQ = 1'b1; alu_raise = 0; end
      if (RD_ACK)  begin RD_REQ = 1'b0;  rd_left--;  rd_raise = (rd_left > 0);  end
      if (ALU_ACK) begin ALU_REQ = 1'b0; alu_left--; alu_raise = (alu_left > 0); end
    end
    RD_REQ  = 1'b0;
    ALU_REQ = 1'b0;
    check("contention_grants_done", rd_left + alu_left, 0);
    wait_sig(S_CBUSY, 1'b0, 600, "contention_frame_done");
    check("contention_ack_total", rd_ack_cnt + alu_ack_cnt - base, 4);
    check("contention_queue_empty", exp_q.size(), 0);

    // Busy high at request blocks the grant
    base = rd_ack_cnt;
    busy_force = 1'b1;
    ack_q.push_back(1'b0);
    exp_q.push_back(8'h77);
    RD_DATA = 8'h77;
    RD_REQ  = 1'b1;
    repeat (20) @(negedge CLK);
    check("busy_blocks_grant", rd_ack_cnt - base, 0);
    busy_force = 1'b0;
    t0 = cyc;
    wait_sig(S_RD_ACK, 1'b1, 10, "busy_release_ack");
    check("busy_release_latency", cyc - t0, 2);
    RD_REQ = 1'b0;
    wait_sig(S_CBUSY, 1'b0, 300, "busy_frame_done");
    check("busy_queue_empty", exp_q.size(), 0);

    // Reset during WAIT_LO of ALU first byte; request held and re-served
    ack_q.push_back(1'b1);
    exp_q.push_back(8'hEF);
    ALU_OUT = 16'hBEEF;
    ALU_REQ = 1'b1;
    wait_sig(S_ALU_ACK, 1'b1, 10, "mid_ack1_seen");
    wait_sig(S_VALID, 1'b1, 10, "mid_valid1_seen");
    repeat (10) @(negedge CLK);
    check("mid_in_wait_lo", {Busy, CTRL_BUSY}, 2'b11);
    RST = 1'b0;
    #1;
    check("mid_rst_ctrl_busy", CTRL_BUSY, 0);
    check("mid_rst_tx_data", TX_P_DATA, 0);
    check("mid_rst_valid_acks", {TX_DATA_VALID, RD_ACK, ALU_ACK}, 0);
    check("mid_rst_err", TIMEOUT_ERR, 0);
    check("mid_queue_drained", exp_q.size(), 0);
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    ack_q.push_back(1'b1);
    exp_q.push_back(8'hEF);
    exp_q.push_back(8'hBE);
    wait_sig(S_ALU_ACK, 1'b1, 300, "mid_ack2_seen");
    ALU_REQ = 1'b0;
    wait_sig(S_CBUSY, 1'b0, 600, "mid_frame_done");
    check("mid_queue_empty", exp_q.size(), 0);

    // Timeout: no Busy response after the strobe
    busy_en = 1'b0;
    ack_q.push_back(1'b0);
    exp_q.push_back(8'h3C);
    RD_DATA = 8'h3C;
    RD_REQ  = 1'b1;
    wait_sig(S_RD_ACK, 1'b1, 10, "to_ack_seen");
    RD_REQ = 1'b0;
    wait_sig(S_VALID, 1'b1, 10, "to_valid_seen");
    t0 = cyc;
    wait_sig(S_ERR, 1'b1, BUSY_TIMEOUT + 20, "to_err_set");
    check("to_latency", cyc - t0, BUSY_TIMEOUT);
    check("to_back_to_idle", CTRL_BUSY, 0);
    busy_en = 1'b1;
    ack_q.push_back(1'b0);
    exp_q.push_back(8'h5A);
    RD_DATA = 8'h5A;
    RD_REQ  = 1'b1;
    wait_sig(S_RD_ACK, 1'b1, 10, "to_next_ack");
    RD_REQ = 1'b0;
    wait_sig(S_VALID, 1'b1, 10, "to_next_valid");
    wait_sig(S_CBUSY, 1'b0, 300, "to_next_done");
    check("to_err_sticky", TIMEOUT_ERR, 1);
    check("final_tx_queue_empty", exp_q.size(), 0);
    check("final_ack_queue_empty", ack_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_scheduler.md
Name: uart_tx_scheduler

Overview:
- Single-clock controller that shares the UART transmitter between two requesters: register-file read data (1 byte) and ALU result (2 bytes, LSB first).
- Arbitrates round-robin, latches the winner's payload, and sequences bytes into the transmitter using the TX_P_DATA / TX_DATA_VALID / Busy handshake.
- Sits between the system control path and the UART TX input.
- Busy arrives already synchronized into this clock domain.

Parameters:
- DATA_WIDTH, 8, width of one UART byte; ALU payload is 2*DATA_WIDTH.
- BUSY_TIMEOUT, 255, cycles to wait for Busy to rise after a TX_DATA_VALID pulse before declaring timeout; counter width is clog2(BUSY_TIMEOUT+1).

Ports:
- CLK  input  1  system clock, rising edge.
- RST  input  1  asynchronous active-low reset.
- RD_DATA  input  DATA_WIDTH  register-read byte; held stable while RD_REQ=1.
- RD_REQ  input  1  register-read transmit request; level, held until RD_ACK.
- RD_ACK  output  1  one-cycle pulse: RD_DATA latched.
- ALU_OUT  input  2*DATA_WIDTH  ALU result; held stable while ALU_REQ=1.
- ALU_REQ  input  1  ALU transmit request; level, held until ALU_ACK.
- ALU_ACK  output  1  one-cycle pulse: ALU_OUT latched.
- Busy  input  1  UART TX busy, synchronized.
- TX_P_DATA  output  DATA_WIDTH  byte to transmitter; registered.
- TX_DATA_VALID  output  1  one-cycle transmit strobe.
- CTRL_BUSY  output  1  high whenever the FSM is not in IDLE.
- TIMEOUT_ERR  output  1  sticky; set on Busy timeout, cleared only by reset.

Behaviour:
- Reset (RST=0, async): state=IDLE. All outputs 0 (TX_P_DATA=0, TX_DATA_VALID=0, RD_ACK=0, ALU_ACK=0, CTRL_BUSY=0, TIMEOUT_ERR=0). Round-robin pointer = RD priority. Byte counter=0. Timeout counter=0.
- Reset mid-frame: the current frame is abandoned. No ACK is re-issued. A requester still holding REQ is re-served after reset.
- States: IDLE, GRANT, SEND, WAIT_HI, WAIT_LO.
- IDLE:
  - If Busy=0 and any REQ is high, go to GRANT.
  - Busy=1 in IDLE (transmitter owned elsewhere or finishing) blocks the grant.
- GRANT (1 cycle):
  - Pick the winner: if both REQs are high, serve the one the pointer favours, then toggle the pointer to the other; a single REQ wins outright.
  - Latch payload into a 2*DATA_WIDTH shift register. RD payload is zero-extended with byte count 1; ALU payload has byte count 2.
  - Pulse the matching ACK this cycle, then go to SEND.
- SEND (1 cycle):
  - TX_P_DATA = low byte of the shift register; TX_DATA_VALID=1 for exactly this cycle.
  - Clear the timeout counter, go to WAIT_HI.
- WAIT_HI:
  - Busy=1: go to WAIT_LO.
  - Otherwise increment the timeout counter. When it reaches BUSY_TIMEOUT, set TIMEOUT_ERR, drop the rest of the frame and go to IDLE.
- WAIT_LO:
  - Wait for Busy=0. Then decrement the byte count and shift the register right by DATA_WIDTH.
  - If the remaining count is 0, go to IDLE; else go to SEND.
  - No timeout applies in WAIT_LO.
- Latency:
  - REQ rising (Busy=0, no contention) to ACK: 2 cycles (IDLE→GRANT).
  - REQ rising to first TX_DATA_VALID: 3 cycles.
  - Busy falling to the next byte's TX_DATA_VALID: 2 cycles.
- TX_P_DATA holds its last value outside SEND. It is valid at least from the SEND cycle until Busy rises.
- CTRL_BUSY is registered with the state, so it is high from GRANT through the cycle WAIT_LO exits.
- Simultaneous REQ: fairness is strict alternation. Back-to-back requests from one side never starve the other.
- A REQ dropping before ACK is a protocol violation; behaviour is unspecified and need not be checked.
- ACK is never asserted twice for one latched request.

Test Plan:
- Single RD: RD_DATA=0xA5, RD_REQ=1, Busy model rises 2 cycles after valid and falls 100 cycles later → RD_ACK pulses once; exactly one TX_DATA_VALID with TX_P_DATA=0xA5; CTRL_BUSY drops after Busy falls.
- Single ALU: ALU_OUT=0x1234 → two TX_DATA_VALID pulses, 0x34 then 0x12. The second pulse comes 2 cycles after Busy falls from the first byte.
- Contention: RD_REQ and ALU_REQ rise in the same cycle, both re-requesting after each ACK for 4 frames → grant order RD, ALU, RD, ALU; byte stream alternates 1-byte and 2-byte frames.
- Timeout: Busy held 0 after TX_DATA_VALID → TIMEOUT_ERR=1 exactly BUSY_TIMEOUT cycles after WAIT_HI entry. FSM returns to IDLE; the next RD_REQ is served normally with TIMEOUT_ERR still 1.
- Reset mid-frame: RST=0 asserted during WAIT_LO of the ALU first byte → all outputs 0 immediately (async). With ALU_REQ still high after release, ALU_ACK fires again and both bytes are resent.
- Busy high at request: Busy=1 when RD_REQ rises → no ACK until Busy=0; then ACK follows 2 cycles later.
